// File: rtl/ps2_host_tx_if.sv
// Command handshake and transfer status between a command source and ps2_host_tx.
interface ps2_host_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic       tx_done;
    logic       tx_error;

    modport master (
        output tx_data, tx_valid,
        input  tx_ready, busy, tx_done, tx_error
    );

    modport slave (
        input  tx_data, tx_valid,
        output tx_ready, busy, tx_done, tx_error
    );
endinterface

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the clock, issues request-to-send, shifts one
// command byte with odd parity on device clock edges and reports ACK, NACK or timeout.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic         clock,
    input  logic         resetn,
    ps2_host_tx_if.slave bus,
    input  logic         ps2c_in,
    input  logic         ps2d_in,
    output logic         ps2c_oe,
    output logic         ps2d_oe
);
    localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        RTS,
        SHIFT,
        WAIT_IDLE
    } state_t;

    state_t           state;
    logic [1:0]       ps2c_sync;
    logic [1:0]       ps2d_sync;
    logic             ps2c_prev;
    logic [8:0]       frame;
    logic [3:0]       bitcnt;
    logic [INH_W-1:0] inh_cnt;
    logic [TMO_W-1:0] tmo_cnt;

    logic       ps2c_s;
    logic       ps2d_s;
    logic       fe;
    logic       timeout_hit;
    logic [3:0] bitcnt_next;
    logic [3:0] bit_idx;

    assign ps2c_s      = ps2c_sync[1];
    assign ps2d_s      = ps2d_sync[1];
    assign fe          = ps2c_prev & ~ps2c_s;
    assign timeout_hit = ((state == SHIFT) || (state == WAIT_IDLE)) && (tmo_cnt == TMO_LAST);
    assign bitcnt_next = bitcnt + 4'd1;
    assign bit_idx     = bitcnt_next - 4'd1;

    // NOTE: synchronisers reset to the idle-high line level so leaving reset cannot fake a falling edge.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            ps2c_sync <= 2'b11;
            ps2d_sync <= 2'b11;
            ps2c_prev <= 1'b1;
        end else begin
            ps2c_sync <= {ps2c_sync[0], ps2c_in};
            ps2d_sync <= {ps2d_sync[0], ps2d_in};
            ps2c_prev <= ps2c_sync[1];
        end
    end

    // NOTE: non-blocking assignments make every branch read pre-edge values, so outputs stay registered.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state        <= IDLE;
            bus.tx_ready <= 1'b1;
            bus.busy     <= 1'b0;
            bus.tx_done  <= 1'b0;
            bus.tx_error <= 1'b0;
            ps2c_oe      <= 1'b0;
            ps2d_oe      <= 1'b0;
            frame        <= '0;
            bitcnt       <= '0;
            inh_cnt      <= '0;
            tmo_cnt      <= '0;
        end else begin
            bus.tx_done  <= 1'b0;
            bus.tx_error <= 1'b0;

            if (timeout_hit) begin
                // Device stopped clocking: abandon the frame even if an edge arrives now.
                state        <= IDLE;
                bus.busy     <= 1'b0;
                bus.tx_error <= 1'b1;
                ps2c_oe      <= 1'b0;
                ps2d_oe      <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        bus.tx_ready <= 1'b1;
                        bus.busy     <= 1'b0;
                        ps2c_oe      <= 1'b0;
                        ps2d_oe      <= 1'b0;
                        if (bus.tx_valid && bus.tx_ready) begin
                            frame        <= {~^bus.tx_data, bus.tx_data};
                            inh_cnt      <= '0;
                            state        <= INHIBIT;
                            bus.tx_ready <= 1'b0;
                            bus.busy     <= 1'b1;
                            ps2c_oe      <= 1'b1;
                        end
                    end

                    INHIBIT: begin
                        if (inh_cnt == INH_LAST) begin
                            state   <= RTS;
                            inh_cnt <= '0;
                            ps2d_oe <= 1'b1;
                        end else begin
                            inh_cnt <= inh_cnt + INH_W'(1);
                        end
                    end

                    RTS: begin
                        state   <= SHIFT;
                        ps2c_oe <= 1'b0;
                        bitcnt  <= '0;
                        tmo_cnt <= '0;
                    end

                    SHIFT: begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                        if (fe) begin
                            bitcnt <= bitcnt_next;
                            // Edges 1..9 present data LSB first then parity; 10 releases for stop.
                            if (bitcnt_next <= 4'd9) begin
                                ps2d_oe <= ~frame[bit_idx];
                            end else if (bitcnt_next == 4'd10) begin
                                ps2d_oe <= 1'b0;
                            end else if (ps2d_s) begin
                                state        <= IDLE;
                                bus.busy     <= 1'b0;
                                bus.tx_error <= 1'b1;
                                ps2d_oe      <= 1'b0;
                            end else begin
                                state   <= WAIT_IDLE;
                                ps2d_oe <= 1'b0;
                            end
                        end
                    end

                    WAIT_IDLE: begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                        if (ps2c_s && ps2d_s) begin
                            state       <= IDLE;
                            bus.busy    <= 1'b0;
                            bus.tx_done <= 1'b1;
                        end
                    end

                    default: begin
                        state        <= IDLE;
                        bus.busy     <= 1'b0;
                        bus.tx_ready <= 1'b0;
                        ps2c_oe      <= 1'b0;
                        ps2d_oe      <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model clocks frames in, a scoreboard queue holds the
// expected outcome of every issued command and a monitor checks each done/error pulse.
module tb_ps2_host_tx;
    localparam int INH    = 20;
    localparam int TMO    = 2000;
    localparam int HALF   = 8;
    localparam int BUDGET = 20000;

    typedef struct {
        logic [7:0] data;
        logic       par;
        bit         ok;
        bit         chk_rx;
        bit         chk_lat;
    } exp_t;

    exp_t exp_q[$];

    logic        clock   = 1'b0;
    logic        resetn  = 1'b0;
    logic        dev_clk = 1'b1;
    logic        dev_dat = 1'b1;
    logic        ps2c_in, ps2d_in, ps2c_oe, ps2d_oe;
    logic [10:0] rx_frame = '0;
    int          cyc      = 0;
    int          t_shift  = 0;
    int          checks   = 0;
    int          errors   = 0;

    ps2_host_tx_if bus ();

    assign ps2c_in = dev_clk & ~ps2c_oe;
    assign ps2d_in = dev_dat & ~ps2d_oe;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clock   (clock),
        .resetn  (resetn),
        .bus     (bus),
        .ps2c_in (ps2c_in),
        .ps2d_in (ps2d_in),
        .ps2c_oe (ps2c_oe),
        .ps2d_oe (ps2d_oe)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    function automatic exp_t mk(input logic [7:0] d, input logic p, input bit ok,
                                input bit rx, input bit lat);
        exp_t e;
        e.data = d; e.par = p; e.ok = ok; e.chk_rx = rx; e.chk_lat = lat;
        return e;
    endfunction

    // Monitor: pops one expectation per pulse; also checks pulse width and the ready hand-off.
    initial begin : monitor
        exp_t e;
        bit   prev_pulse;
        prev_pulse = 1'b0;
        forever begin
            @(negedge clock);
            if (!resetn) begin
                prev_pulse = 1'b0;
            end else begin
                if (prev_pulse) begin
                    check("pulse_width", {bus.tx_done, bus.tx_error}, 2'b00);
                    check("ready_after_pulse", bus.tx_ready, 1'b1);
                end
                prev_pulse = bus.tx_done | bus.tx_error;
                if (prev_pulse) begin
                    check("lines_released", {ps2c_oe, ps2d_oe}, 2'b00);
                    check("busy_at_pulse", bus.busy, 1'b0);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_pulse: done=%0b error=%0b with nothing pending",
                                 bus.tx_done, bus.tx_error);
                    end else begin
                        e = exp_q.pop_front();
                        check("result", {bus.tx_done, bus.tx_error}, e.ok ? 2'b10 : 2'b01);
                        if (e.chk_rx) begin
                            check("rx_start", rx_frame[0], 1'b0);
                            check("rx_data", rx_frame[8:1], e.data);
                            check("rx_parity", rx_frame[9], e.par);
                            check("rx_stop", rx_frame[10], 1'b1);
                        end
                        if (e.chk_lat) check("timeout_latency", cyc - t_shift, TMO);
                    end
                end
            end
        end
    end

    task automatic issue(input logic [7:0] d, input bit hold);
        int n = 0;
        while (!bus.tx_ready && n < BUDGET) begin
            @(negedge clock);
            n++;
        end
        check("ready_wait", n < BUDGET, 1'b1);
        bus.tx_data  = d;
        bus.tx_valid = 1'b1;
        @(negedge clock);
        if (!hold) bus.tx_valid = 1'b0;
    endtask

    // Starts on the first cycle after accept; ends on the first SHIFT cycle.
    task automatic check_preamble();
        int n = 0;
        check("accept_busy", bus.busy, 1'b1);
        while (ps2c_oe && !ps2d_oe && n < BUDGET) begin
            n++;
            @(negedge clock);
        end
        check("inhibit_len", n, INH);
        n = 0;
        while (ps2c_oe && ps2d_oe && n < BUDGET) begin
            n++;
            @(negedge clock);
        end
        check("rts_len", n, 1);
        check("shift_lines", {ps2c_oe, ps2d_oe}, 2'b01);
        t_shift = cyc;
    endtask

    // Device model: n_fe clock pulses, sampling host data before each rising edge.
    // With n_fe < 11 it returns right after the last falling edge, clock still low.
    task automatic device_xfer(input int n_fe, input bit ack);
        rx_frame    = '0;
        rx_frame[0] = ps2d_in;
        for (int k = 1; k <= n_fe; k++) begin
            repeat (HALF) @(negedge clock);
            dev_clk = 1'b0;
            if (k == 11 && ack) dev_dat = 1'b0;
            if (k < n_fe || n_fe == 11) begin
                repeat (HALF) @(negedge clock);
                if (k <= 10) rx_frame[k] = ps2d_in;
                dev_clk = 1'b1;
                dev_dat = 1'b1;
            end
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!bus.tx_ready && n < BUDGET) begin
            @(negedge clock);
            n++;
        end
        check("idle_wait", n < BUDGET, 1'b1);
    endtask

    task automatic xfer_ok(input logic [7:0] d, input logic par);
        issue(d, 1'b0);
        exp_q.push_back(mk(d, par, 1'b1, 1'b1, 1'b0));
        check_preamble();
        device_xfer(11, 1'b1);
        wait_idle();
    endtask

    initial begin : stimulus
        int n;
        bus.tx_data  = 8'h00;
        bus.tx_valid = 1'b0;
        repeat (3) @(negedge clock);
        check("reset_ready", bus.tx_ready, 1'b1);
        check("reset_status", {bus.busy, bus.tx_done, bus.tx_error}, 3'b000);
        check("reset_lines", {ps2c_oe, ps2d_oe}, 2'b00);
        resetn = 1'b1;
        @(negedge clock);
        check("idle_ready", bus.tx_ready, 1'b1);

        // Normal transfers: ED parity 1, F4 parity 0, 00 parity 1.
        xfer_ok(8'hED, 1'b1);
        xfer_ok(8'hF4, 1'b0);
        xfer_ok(8'h00, 1'b1);

        // Device leaves data high at the 11th edge.
        issue(8'h12, 1'b0);
        exp_q.push_back(mk(8'h12, 1'b1, 1'b0, 1'b1, 1'b0));
        check_preamble();
        device_xfer(11, 1'b0);
        wait_idle();

        // Device never clocks after request-to-send.
        issue(8'h3C, 1'b0);
        exp_q.push_back(mk(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1));
        check_preamble();
        wait_idle();

        // Reset after the 4th edge of 0x00: bit 3 is 0, so data is pulled low until reset.
        issue(8'h00, 1'b0);
        check_preamble();
        device_xfer(4, 1'b0);
        repeat (3) @(negedge clock);
        check("abort_mid_shift", {ps2c_oe, ps2d_oe}, 2'b01);
        resetn = 1'b0;
        @(negedge clock);
        check("abort_lines", {ps2c_oe, ps2d_oe}, 2'b00);
        check("abort_ready", bus.tx_ready, 1'b1);
        check("abort_pulses", {bus.tx_done, bus.tx_error}, 2'b00);
        dev_clk = 1'b1;
        @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);
        xfer_ok(8'hFF, 1'b1);

        // tx_valid held high; data changes after accept and is taken only by the next accept.
        issue(8'h5A, 1'b1);
        exp_q.push_back(mk(8'h5A, 1'b1, 1'b1, 1'b1, 1'b0));
        bus.tx_data = 8'h07;
        check_preamble();
        device_xfer(11, 1'b1);
        n = 0;
        while (!bus.tx_done && n < BUDGET) begin
            @(negedge clock);
            n++;
        end
        check("done_wait", n < BUDGET, 1'b1);
        @(negedge clock);
        check("b2b_ready", bus.tx_ready, 1'b1);
        @(negedge clock);
        check("b2b_accept", {bus.busy, ps2c_oe}, 2'b11);
        exp_q.push_back(mk(8'h07, 1'b0, 1'b1, 1'b1, 1'b0));
        bus.tx_valid = 1'b0;
        check_preamble();
        device_xfer(11, 1'b1);
        wait_idle();

        repeat (5) @(negedge clock);
        check("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
